// File: rtl/pad_mux_ctrl_if.sv
// Configuration register bus of pad_mux_ctrl: single-cycle write/read strobes,
// registered read data returned with a one-cycle valid pulse.
interface pad_mux_ctrl_if;
    logic [5:0]  cfg_addr;
    logic        cfg_we;
    logic        cfg_re;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;

    modport master (
        output cfg_addr, cfg_we, cfg_re, cfg_wdata,
        input  cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  cfg_addr, cfg_we, cfg_re, cfg_wdata,
        output cfg_rdata, cfg_rvalid
    );
endinterface

// File: rtl/pad_mux_ctrl.sv
// Runtime pad function multiplexer with per-pad input synchroniser, glitch
// filter and write-1-to-clear change-event status feeding a registered IRQ.
module pad_mux_ctrl #(
    parameter int unsigned NUM_PADS = 14,
    parameter int unsigned NUM_FUNC = 4,
    parameter int unsigned FILT_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pad_mux_ctrl_if.slave                bus,
    input  logic [NUM_PADS*NUM_FUNC-1:0] func_o,
    input  logic [NUM_PADS*NUM_FUNC-1:0] func_oe,
    output logic [NUM_PADS*NUM_FUNC-1:0] func_i,
    output logic [NUM_PADS-1:0]          pad_o,
    output logic [NUM_PADS-1:0]          pad_oe,
    input  logic [NUM_PADS-1:0]          pad_i,
    output logic                         irq_o
);
    localparam int unsigned SEL_W       = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;
    localparam logic [5:0]  STATUS_ADDR = 6'(NUM_PADS);

    logic [NUM_PADS-1:0][SEL_W-1:0]  sel_q;
    logic [NUM_PADS-1:0]             filt_en_q;
    logic [NUM_PADS-1:0]             irq_en_q;
    logic [NUM_PADS-1:0][FILT_W-1:0] thr_q;

    logic [NUM_PADS-1:0]             sync1_q;
    logic [NUM_PADS-1:0]             sync2_q;
    logic [NUM_PADS-1:0]             filt_q;
    logic [NUM_PADS-1:0]             filt_d;
    logic [NUM_PADS-1:0]             filt_prev_q;
    logic [NUM_PADS-1:0][FILT_W-1:0] cnt_q;
    logic [NUM_PADS-1:0][FILT_W-1:0] cnt_d;

    logic [NUM_PADS-1:0]             status_q;
    logic [NUM_PADS-1:0]             status_d;
    logic                            irq_q;

    logic [31:0]                     rdata_q;
    logic [31:0]                     rdata_d;
    logic                            rvalid_q;
    logic [NUM_PADS-1:0][31:0]       cfg_word;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_word
        assign cfg_word[g] = {{(20 - FILT_W){1'b0}}, thr_q[g], 2'b00,
                              irq_en_q[g], filt_en_q[g],
                              {(8 - SEL_W){1'b0}}, sel_q[g]};
    end

    // Out-of-range selections match no function index, leaving the pad undriven.
    always_comb begin
        pad_o  = '0;
        pad_oe = '0;
        func_i = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            for (int unsigned f = 0; f < NUM_FUNC; f++) begin
                if (sel_q[p] == SEL_W'(f)) begin
                    pad_o[p]                = func_o[p*NUM_FUNC + f];
                    pad_oe[p]               = func_oe[p*NUM_FUNC + f];
                    func_i[p*NUM_FUNC + f]  = filt_q[p];
                end
            end
        end
    end

    // A thr of 0 or 1 lets the first disagreeing sample through.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            if (!filt_en_q[p]) begin
                filt_d[p] = sync2_q[p];
                cnt_d[p]  = '0;
            end else if (sync2_q[p] == filt_q[p]) begin
                cnt_d[p] = '0;
            end else if (thr_q[p] <= FILT_W'(1) || cnt_q[p] >= thr_q[p] - FILT_W'(1)) begin
                filt_d[p] = sync2_q[p];
                cnt_d[p]  = '0;
            end else begin
                cnt_d[p] = cnt_q[p] + FILT_W'(1);
            end
        end
    end

    // New events are ORed in after the clear so a coincident set survives.
    always_comb begin
        status_d = status_q;
        if (bus.cfg_we && bus.cfg_addr == STATUS_ADDR) begin
            status_d = status_q & ~bus.cfg_wdata[NUM_PADS-1:0];
        end
        status_d = status_d | ((filt_q ^ filt_prev_q) & irq_en_q);
    end

    always_comb begin
        rdata_d = '0;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
            if (bus.cfg_addr == 6'(p)) begin
                rdata_d = cfg_word[p];
            end
        end
        if (bus.cfg_addr == STATUS_ADDR) begin
            rdata_d = 32'(status_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            filt_en_q   <= '0;
            irq_en_q    <= '0;
            thr_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            filt_q      <= '0;
            filt_prev_q <= '0;
            cnt_q       <= '0;
            status_q    <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            sync1_q     <= pad_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            irq_q       <= |status_q;
            rvalid_q    <= bus.cfg_re;
            if (bus.cfg_re) begin
                rdata_q <= rdata_d;
            end
            for (int unsigned p = 0; p < NUM_PADS; p++) begin
                if (bus.cfg_we && bus.cfg_addr == 6'(p)) begin
                    sel_q[p]     <= bus.cfg_wdata[SEL_W-1:0];
                    filt_en_q[p] <= bus.cfg_wdata[8];
                    irq_en_q[p]  <= bus.cfg_wdata[9];
                    thr_q[p]     <= bus.cfg_wdata[12 +: FILT_W];
                end
            end
        end
    end

    assign bus.cfg_rdata  = rdata_q;
    assign bus.cfg_rvalid = rvalid_q;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Directed bench for pad_mux_ctrl with a cycle-level behavioural model checked
// every cycle, plus literal expectations at the interesting points.
module tb_pad_mux_ctrl;
    localparam int NP = 14;
    localparam int NF = 3;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pad_mux_ctrl_if bus();
    logic [NP*NF-1:0] func_o, func_oe, func_i;
    logic [NP-1:0]    pad_o, pad_oe, pad_i;
    logic             irq_o;

    pad_mux_ctrl #(.NUM_PADS(NP), .NUM_FUNC(NF), .FILT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .func_o(func_o), .func_oe(func_oe), .func_i(func_i),
        .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i), .irq_o(irq_o)
    );

    int total = 0;
    int bad = 0;

    // Model state: configuration, two synchroniser stages, filtered value and
    // its previous value, length of the current run of disagreeing samples.
    int msel[NP], mthr[NP], run[NP];
    bit mfen[NP], mien[NP], s1[NP], s2[NP], mf[NP], mfp[NP], mst[NP];
    bit mirq, mrv;
    logic [31:0] mrd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            msel[p] = 0; mthr[p] = 0; run[p] = 0;
            mfen[p] = 0; mien[p] = 0; s1[p] = 0; s2[p] = 0;
            mf[p] = 0; mfp[p] = 0; mst[p] = 0;
        end
        mirq = 0; mrv = 0; mrd = '0;
    endtask

    function automatic logic [31:0] word(input int p);
        return 32'(msel[p]) | (32'(mfen[p]) << 8) | (32'(mien[p]) << 9) | (32'(mthr[p]) << 12);
    endfunction

    task automatic model_edge();
        int a;
        bit any;
        logic [31:0] st;
        a = int'(bus.cfg_addr);
        st = '0;
        any = 0;
        for (int p = 0; p < NP; p++) begin
            st[p] = mst[p];
            any |= mst[p];
        end
        mrv = bus.cfg_re;
        if (bus.cfg_re) mrd = (a < NP) ? word(a) : ((a == NP) ? st : 32'h0);
        mirq = any;
        for (int p = 0; p < NP; p++) begin
            bit clr;
            int teff;
            clr = bus.cfg_we && (a == NP) && bus.cfg_wdata[p];
            mst[p] = (mst[p] && !clr) || ((mf[p] != mfp[p]) && mien[p]);
            mfp[p] = mf[p];
            teff = (mthr[p] == 0) ? 1 : mthr[p];
            if (!mfen[p]) begin
                mf[p] = s2[p];
                run[p] = 0;
            end else if (s2[p] == mf[p]) begin
                run[p] = 0;
            end else begin
                run[p] = run[p] + 1;
                if (run[p] >= teff) begin
                    mf[p] = s2[p];
                    run[p] = 0;
                end
            end
            s2[p] = s1[p];
            s1[p] = pad_i[p];
        end
        if (bus.cfg_we && a < NP) begin
            msel[a] = int'(bus.cfg_wdata[1:0]);
            mfen[a] = bus.cfg_wdata[8];
            mien[a] = bus.cfg_wdata[9];
            mthr[a] = int'(bus.cfg_wdata[15:12]);
        end
    endtask

    task automatic compare();
        logic [NP-1:0] epo, epoe;
        logic [NP*NF-1:0] efi;
        epo = '0; epoe = '0; efi = '0;
        for (int p = 0; p < NP; p++) begin
            if (msel[p] < NF) begin
                epo[p] = func_o[p*NF + msel[p]];
                epoe[p] = func_oe[p*NF + msel[p]];
                efi[p*NF + msel[p]] = mf[p];
            end
        end
        check("pad_o", 64'(pad_o), 64'(epo));
        check("pad_oe", 64'(pad_oe), 64'(epoe));
        check("func_i", 64'(func_i), 64'(efi));
        check("irq_o", 64'(irq_o), 64'(mirq));
        check("cfg_rvalid", 64'(bus.cfg_rvalid), 64'(mrv));
        if (mrv) check("cfg_rdata", 64'(bus.cfg_rdata), 64'(mrd));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        compare();
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.cfg_addr = 6'(a); bus.cfg_wdata = d; bus.cfg_we = 1'b1;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.cfg_addr = 6'(a); bus.cfg_re = 1'b1;
        step();
        d = bus.cfg_rdata;
        bus.cfg_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        bus.cfg_addr = '0; bus.cfg_we = 1'b0; bus.cfg_re = 1'b0; bus.cfg_wdata = '0;
        func_o  = 42'(64'h0123_4567_89AB_CDEF);
        func_oe = 42'(64'hFEDC_BA98_7654_3210);
        pad_i = '0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        check("reset_irq", 64'(irq_o), 64'h0);
        check("reset_func_i", 64'(func_i), 64'h0);
        for (int a = 0; a <= NP; a++) begin
            rd(a, d);
            check("reset_read", 64'(d), 64'h0);
        end

        // Pad 3 to function 2.
        func_o[3*NF+2] = 1'b1; func_oe[3*NF+2] = 1'b1;
        func_o[3*NF+0] = 1'b0; func_oe[3*NF+0] = 1'b0;
        step();
        check("pad3_before", 64'(pad_oe[3]), 64'h0);
        wr(3, 32'h2);
        check("pad3_o", 64'(pad_o[3]), 64'h1);
        check("pad3_oe", 64'(pad_oe[3]), 64'h1);
        check("pad3_fi0", 64'(func_i[3*NF+0]), 64'h0);

        // Pad 5: filter on, thr 4; a 3-cycle glitch is absorbed.
        wr(5, 32'h0000_4100);
        pad_i[5] = 1'b1;
        cyc(3);
        pad_i[5] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("glitch_fi", 64'(func_i[5*NF]), 64'h0);
        end
        pad_i[5] = 1'b1;
        step();
        for (int i = 1; i <= 9; i++) begin
            step();
            check("filt_latency", 64'(func_i[5*NF]), (i >= 5) ? 64'h1 : 64'h0);
        end
        pad_i[5] = 1'b0;
        cyc(10);

        // Pad 1 change events and W1C.
        wr(1, 32'h200);
        pad_i[1] = 1'b1;
        cyc(5);
        check("irq_set", 64'(irq_o), 64'h1);
        rd(NP, d);
        check("status_set", 64'(d), 64'h2);
        pad_i[1] = 1'b0;
        cyc(3);
        wr(NP, 32'h2);
        rd(NP, d);
        check("set_wins", 64'(d), 64'h2);
        cyc(3);
        wr(NP, 32'h2);
        step();
        check("irq_clear", 64'(irq_o), 64'h0);
        rd(NP, d);
        check("status_clear", 64'(d), 64'h0);

        // Unmapped address, read-during-write, out-of-range select.
        wr(40, 32'hFFFF_FFFF);
        rd(40, d);
        check("unmapped_read", 64'(d), 64'h0);
        rd(3, d);
        check("cfg3_kept", 64'(d), 64'h2);
        func_oe[3*NF +: NF] = 3'b111;
        func_o[3*NF +: NF] = 3'b111;
        wr(3, 32'h3);
        check("sel_oor_oe", 64'(pad_oe[3]), 64'h0);
        check("sel_oor_o", 64'(pad_o[3]), 64'h0);
        bus.cfg_addr = 6'd3; bus.cfg_wdata = 32'h1; bus.cfg_we = 1'b1; bus.cfg_re = 1'b1;
        step();
        d = bus.cfg_rdata;
        bus.cfg_we = 1'b0; bus.cfg_re = 1'b0;
        check("rd_pre_write", 64'(d), 64'h3);
        check("rw_new_sel", 64'(pad_o[3]), 64'h1);

        // Asynchronous reset during a filter count and a pending read.
        pad_i[1] = 1'b1; pad_i[5] = 1'b1;
        cyc(5);
        check("pre_reset_irq", 64'(irq_o), 64'h1);
        bus.cfg_addr = 6'(NP); bus.cfg_re = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_irq", 64'(irq_o), 64'h0);
        check("areset_rvalid", 64'(bus.cfg_rvalid), 64'h0);
        check("areset_rdata", 64'(bus.cfg_rdata), 64'h0);
        check("areset_func_i", 64'(func_i), 64'h0);
        compare();
        cyc(2);
        bus.cfg_re = 1'b0;
        rst_n = 1'b1;
        cyc(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
